csa8_result_accum: RTL and testbench
====================================

Name: csa8_result_accum

Overview:
- Downstream consumer of the 8-bit carry-select adder stage.
- Takes each adder result {cout, sum[7:0]} as a 9-bit unsigned value over a valid/ready handshake and accumulates BATCH results into a running total.
- Presents the batch total plus a sticky overflow flag on an output valid/ready handshake toward the tile output mux.
- Holds the result until it is accepted, then starts a new batch.

Parameters:
- DATA_W, 8, adder sum width; the input value is DATA_W+1 bits including cout.
- ACC_W, 12, accumulator width; must be >= DATA_W+1.
- BATCH, 8, number of accepted inputs per output result; must be >= 1.

Ports:
- clk  input  1  single design clock.
- rst  input  1  synchronous reset, active-high.
- sum_in  input  DATA_W  adder sum.
- cout_in  input  1  adder carry-out.
- in_valid  input  1  sum_in/cout_in valid.
- in_ready  output  1  block can accept an input this cycle.
- flush  input  1  one-cycle request to close a partial batch early.
- out_valid  output  1  acc_out/ovf_out/cnt_out valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  batch total.
- ovf_out  output  1  sticky: the batch total exceeded ACC_W bits.
- cnt_out  output  $clog2(BATCH+1)  number of inputs in the presented batch.

Behaviour:
- Synchronous, active-high reset, sampled on the clk rising edge:
  - state=ACCUM; acc, count and ovf cleared to 0.
  - out_valid=0; acc_out, ovf_out and cnt_out are 0.
  - in_ready=1 in the first cycle after rst deasserts.
- Reset asserted mid-batch or mid-present discards all data; no result is emitted.
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - PRESENT: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready.
- Input accept = in_valid && in_ready.
- On accept:
  - acc <= acc + zero_extend({cout_in, sum_in}) mod 2^ACC_W.
  - ovf is set if that add carries out of bit ACC_W-1; once set it stays set until the batch is consumed.
  - count <= count + 1.
- ACCUM -> PRESENT on the edge where:
  - an accept brings count to BATCH; or
  - flush=1 and (count > 0 or an accept occurs the same cycle).
- flush with an accept in the same cycle: the input is included, then the block presents.
- flush with count=0 and no accept: ignored, state stays ACCUM.
- flush while in PRESENT: ignored.
- In PRESENT, acc_out, ovf_out and cnt_out are stable and equal the registered totals.
- Inputs are not accepted while in PRESENT.
- PRESENT -> ACCUM on out_valid && out_ready:
  - acc, count and ovf cleared.
  - in_ready=1 on the next cycle.
- Latency:
  - The result is visible (out_valid=1) in the cycle after the final accept.
  - At most one result per BATCH+1 cycles under full throughput.
- Outside PRESENT, acc_out, ovf_out and cnt_out drive 0.

Optional Feature:
- CSA_ACCUM_SATURATE_EN defined:
  - on any add that would exceed 2^ACC_W-1, acc clamps to 2^ACC_W-1 and ovf is set.
  - further adds in the batch keep acc at the maximum.
- Not defined: modular wrap as described in Behaviour, with ovf still set.
- Handshake timing is identical in both builds.

Decomposition:
- Package csa8_pkg:
  - typedef of the state enum (ACCUM, PRESENT);
  - constants CSA8_DATA_W=8 and CSA8_ACC_W_DEF=12;
  - function cnt_width(batch) returning $clog2(batch+1).
- No sub-module: a single flat module with one always_ff for state/acc/count/ovf and combinational output decode.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release -> out_valid=0, acc_out=0, ovf_out=0, in_ready=1 in the first post-reset cycle.
- Full batch: defaults, feed 8 inputs of {cout=1, sum=0xFF} (0x1FF) back-to-back with out_ready=0 -> the cycle after the 8th, out_valid=1, acc_out=0xFF8, cnt_out=8, ovf_out=0, in_ready=0. Result stays stable 5 cycles; assert out_ready -> next cycle in_ready=1.
- Early flush: feed 0x012, then 0x0034 with flush=1 in the same cycle -> acc_out=0x046, cnt_out=2. flush alone with count=0 -> no out_valid.
- Overflow wrap: ACC_W=10, BATCH=4, feed 0x1FF three times then flush -> acc_out=0x1FD, ovf_out=1, cnt_out=3.
- Saturate build: same stimulus with CSA_ACCUM_SATURATE_EN -> acc_out=0x3FF, ovf_out=1.
- Backpressure/reset mid-op: in PRESENT, hold in_valid=1 with out_ready=0 -> no input is consumed. Assert rst for 1 cycle mid-batch after 3 inputs -> out_valid=0, a fresh batch of 8 x 0x001 gives acc_out=0x008.

Source files
------------

// File: rtl/csa8_pkg.sv
// rtl/csa8_pkg.sv - shared types, default widths and sizing helper for csa8 result accumulator
package csa8_pkg;

    // Adder sum width and default accumulator width
    localparam int CSA8_DATA_W    = 8;
    localparam int CSA8_ACC_W_DEF = 12;

    // Accumulator control states: gathering inputs, or holding a result
    typedef enum logic {
        ACCUM   = 1'b0,
        PRESENT = 1'b1
    } csa8_state_e;

    // Bits needed to hold a count from 0 up to and including batch
    function automatic int cnt_width(input int batch);
        return $clog2(batch + 1);
    endfunction

endpackage

// File: rtl/csa8_result_accum.sv
// rtl/csa8_result_accum.sv - batches carry-select adder results into a running total (option: CSA_ACCUM_SATURATE_EN)
module csa8_result_accum
    import csa8_pkg::*;
#(
    parameter int DATA_W = CSA8_DATA_W,
    parameter int ACC_W  = CSA8_ACC_W_DEF,
    parameter int BATCH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            sum_in,
    input  logic                         cout_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             acc_out,
    output logic                         ovf_out,
    output logic [cnt_width(BATCH)-1:0]  cnt_out
);

    localparam int CNT_W = cnt_width(BATCH);
    localparam int PAD_W = ACC_W - DATA_W;

    csa8_state_e        r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic               w_accept;
    logic [ACC_W:0]     w_in_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_last;
    logic               w_close;

    // Handshake flags come straight from the registered state so neither
    // in_valid nor out_ready has a combinational path to them
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == PRESENT);

    assign w_accept  = in_valid && in_ready;

    // The adder result {cout, sum} is treated as an unsigned DATA_W+1 bit value;
    // one extra bit above the accumulator catches the carry-out of the add
    assign w_in_ext  = {{PAD_W{1'b0}}, cout_in, sum_in};
    assign w_sum     = {1'b0, r_acc} + w_in_ext;
    assign w_carry   = w_sum[ACC_W];

`ifdef CSA_ACCUM_SATURATE_EN
    // Clamp at full scale; once at the maximum any nonzero add carries again
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    // Modular wrap; the carry is still recorded in the sticky flag
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    assign w_count_inc = r_count + CNT_W'(1);

    // Close the batch when it fills, or on flush if it holds (or is about to
    // hold) at least one input; a flush on an empty batch is dropped
    assign w_last  = w_accept && (w_count_inc == CNT_W'(BATCH));
    assign w_close = w_last || (flush && ((r_count != '0) || w_accept));

    // State, running total, input count and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_count_inc;
                        r_ovf   <= r_ovf | w_carry;
                    end
                    if (w_close) begin
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    // Result fields are only meaningful while presenting; drive zero otherwise
    assign acc_out = out_valid ? r_acc   : '0;
    assign ovf_out = out_valid ? r_ovf   : 1'b0;
    assign cnt_out = out_valid ? r_count : '0;

endmodule

// File: tb/tb_csa8_result_accum.sv
// tb/tb_csa8_result_accum.sv - directed bench for csa8_result_accum (default and 10-bit/4-deep instances)
module tb_csa8_result_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: DATA_W=8, ACC_W=12, BATCH=8
    logic        rst;
    logic [7:0]  sum_in;
    logic        cout_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] acc_out;
    logic        ovf_out;
    logic [3:0]  cnt_out;

    // Narrow instance: ACC_W=10, BATCH=4
    logic        b_rst;
    logic [7:0]  b_sum_in;
    logic        b_cout_in;
    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_flush;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [9:0]  b_acc_out;
    logic        b_ovf_out;
    logic [2:0]  b_cnt_out;

`ifdef CSA_ACCUM_SATURATE_EN
    localparam logic [31:0] EXP_OVF_ACC = 32'h3FF;
`else
    localparam logic [31:0] EXP_OVF_ACC = 32'h1FD;
`endif

    int n_total = 0;
    int n_fail  = 0;

    csa8_result_accum #(.DATA_W(8), .ACC_W(12), .BATCH(8)) u_dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .cout_in(cout_in),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .ovf_out(ovf_out), .cnt_out(cnt_out)
    );

    csa8_result_accum #(.DATA_W(8), .ACC_W(10), .BATCH(4)) u_dut_b (
        .clk(clk), .rst(b_rst), .sum_in(b_sum_in), .cout_in(b_cout_in),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .acc_out(b_acc_out),
        .ovf_out(b_ovf_out), .cnt_out(b_cnt_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] val, input logic f);
        in_valid = v;
        {cout_in, sum_in} = val;
        flush = f;
    endtask

    task automatic drive_b(input logic v, input logic [8:0] val, input logic f);
        b_in_valid = v;
        {b_cout_in, b_sum_in} = val;
        b_flush = f;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; drive(1'b0, 9'h000, 1'b0);
        b_rst = 1'b1; b_out_ready = 1'b0; drive_b(1'b0, 9'h000, 1'b0);

        // Reset held three cycles, then released
        repeat (3) tick();
        rst = 1'b0; b_rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out",   acc_out,   0);
        check("rst_ovf_out",   ovf_out,   0);
        check("rst_cnt_out",   cnt_out,   0);
        check("rst_in_ready",  in_ready,  1);
        tick();
        check("idle_in_ready", in_ready,  1);

        // Full batch of eight 0x1FF inputs, back-to-back, no downstream ready
        drive(1'b1, 9'h1FF, 1'b0);
        repeat (7) tick();
        check("full_7th_out_valid", out_valid, 0);
        check("full_7th_in_ready",  in_ready,  1);
        tick();
        check("full_out_valid", out_valid, 1);
        check("full_acc_out",   acc_out,   32'hFF8);
        check("full_cnt_out",   cnt_out,   8);
        check("full_ovf_out",   ovf_out,   0);
        check("full_in_ready",  in_ready,  0);

        // Hold in PRESENT with in_valid asserted: nothing consumed, result stable
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_acc_out",   acc_out,   32'hFF8);
            check("hold_cnt_out",   cnt_out,   8);
            check("hold_out_valid", out_valid, 1);
        end

        // Flush while presenting is ignored; then consume
        drive(1'b0, 9'h000, 1'b1);
        tick();
        check("present_flush_acc", acc_out, 32'hFF8);
        drive(1'b0, 9'h000, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_in_ready",  in_ready,  1);
        check("consume_out_valid", out_valid, 0);
        check("consume_acc_out",   acc_out,   0);

        // Early flush on the same cycle as the second input
        drive(1'b1, 9'h012, 1'b0);
        tick();
        drive(1'b1, 9'h034, 1'b1);
        tick();
        drive(1'b0, 9'h000, 1'b0);
        check("flush_out_valid", out_valid, 1);
        check("flush_acc_out",   acc_out,   32'h046);
        check("flush_cnt_out",   cnt_out,   2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush on an empty batch does nothing
        drive(1'b0, 9'h000, 1'b1);
        tick();
        drive(1'b0, 9'h000, 1'b0);
        check("empty_flush_out_valid", out_valid, 0);
        check("empty_flush_in_ready",  in_ready,  1);
        tick();
        check("empty_flush_later", out_valid, 0);

        // Reset after three inputs discards them
        drive(1'b1, 9'h001, 1'b0);
        repeat (3) tick();
        drive(1'b0, 9'h000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready",  in_ready,  1);
        drive(1'b1, 9'h001, 1'b0);
        repeat (8) tick();
        drive(1'b0, 9'h000, 1'b0);
        check("fresh_out_valid", out_valid, 1);
        check("fresh_acc_out",   acc_out,   32'h008);
        check("fresh_cnt_out",   cnt_out,   8);
        check("fresh_ovf_out",   ovf_out,   0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Narrow accumulator: three 0x1FF then a lone flush overflows 10 bits
        drive_b(1'b1, 9'h1FF, 1'b0);
        repeat (3) tick();
        check("ovf_pre_out_valid", b_out_valid, 0);
        drive_b(1'b0, 9'h000, 1'b1);
        tick();
        drive_b(1'b0, 9'h000, 1'b0);
        check("ovf_out_valid", b_out_valid, 1);
        check("ovf_acc_out",   b_acc_out,   EXP_OVF_ACC);
        check("ovf_ovf_out",   b_ovf_out,   1);
        check("ovf_cnt_out",   b_cnt_out,   3);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("ovf_cleared_in_ready", b_in_ready, 1);

        // Narrow accumulator: a full batch of four clears the sticky flag
        drive_b(1'b1, 9'h001, 1'b0);
        repeat (4) tick();
        drive_b(1'b0, 9'h000, 1'b0);
        check("b_full_out_valid", b_out_valid, 1);
        check("b_full_acc_out",   b_acc_out,   32'h004);
        check("b_full_cnt_out",   b_cnt_out,   4);
        check("b_full_ovf_out",   b_ovf_out,   0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
